// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer for the byte-wide data memory: byte/halfword loads,
// halfword stores and ascending block copies, one request at a time.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata_b,
  input  logic [7:0]        mem_rdata_a
);

  localparam logic [1:0] OP_LOAD8   = 2'b00;
  localparam logic [1:0] OP_LOAD16  = 2'b01;
  localparam logic [1:0] OP_STORE16 = 2'b10;
  localparam logic [1:0] OP_COPY    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_LO, S_WR_HI, S_CP_RD, S_CP_WR, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          hold_q, hold_d;
  logic                ready_q, ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [15:0]         resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;

  // State and registered outputs; reset abandons any in-flight operation.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Strobes are computed for the state being entered so they cover its whole cycle.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    dst_d        = dst_q;
    len_d        = len_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = '0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_wdata_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          op_d    = req_op;
          addr_d  = req_addr;
          dst_d   = req_dst;
          len_d   = req_len;
          wdata_d = req_wdata;
          cnt_d   = '0;
          unique case (req_op)
            OP_LOAD8, OP_LOAD16: begin
              state_d    = S_RD;
              mem_addr_d = req_addr;
              mem_read_d = 1'b1;
            end
            OP_STORE16: begin
              state_d     = S_WR_LO;
              mem_addr_d  = req_addr;
              mem_wdata_d = req_wdata[7:0];
              mem_write_d = 1'b1;
            end
            OP_COPY: begin
              if (req_len == '0) begin
                state_d      = S_DONE;
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
              end else begin
                state_d    = S_CP_RD;
                mem_addr_d = req_addr;
                mem_read_d = 1'b1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          ready_d = 1'b1;
        end
      end
      S_RD: begin
        state_d      = S_DONE;
        resp_valid_d = 1'b1;
        resp_rdata_d = (op_q == OP_LOAD16) ? {mem_rdata_a, mem_rdata_b}
                                           : {8'h00, mem_rdata_b};
      end
      S_WR_LO: begin
        state_d     = S_WR_HI;
        mem_addr_d  = addr_q + ADDR_W'(1);
        mem_wdata_d = wdata_q[15:8];
        mem_write_d = 1'b1;
      end
      S_WR_HI: begin
        state_d      = S_DONE;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
      end
      S_CP_RD: begin
        state_d     = S_CP_WR;
        hold_d      = mem_rdata_b;
        mem_addr_d  = dst_q + ADDR_W'(cnt_q);
        mem_wdata_d = hold_d;
        mem_write_d = 1'b1;
      end
      S_CP_WR: begin
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = 16'(len_q);
        end else begin
          state_d    = S_CP_RD;
          cnt_d      = cnt_q + LEN_W'(1);
          mem_addr_d = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);
          mem_read_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized bench for mem_access_ctrl against a transaction-level
// model of loads, stores and copies over a 256-byte memory.
module tb_mem_access_ctrl;

  logic        CLK;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_addr;
  logic [7:0]  req_dst;
  logic [7:0]  req_len;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [7:0]  mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata_b;
  logic [7:0]  mem_rdata_a;

  mem_access_ctrl #(.ADDR_W(8), .LEN_W(8)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_dst(req_dst), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata_b(mem_rdata_b), .mem_rdata_a(mem_rdata_a)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Environment memory (the DUT's data_mem) with a bench preload port.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       pl_we;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;

  assign mem_rdata_b = mem[mem_addr];
  assign mem_rdata_a = mem[8'(mem_addr + 8'd1)];

  always @(posedge CLK) begin
    if (mem_write === 1'b1) mem[mem_addr] <= mem_wdata;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end

  // Strobe log entry: {is_write, addr, data}
  logic [16:0] log_q [$];
  logic [16:0] exp_q [$];
  int          both_seen = 0;

  always @(negedge CLK) begin
    if (mem_read === 1'b1 && mem_write === 1'b1) both_seen++;
    if (mem_write === 1'b1) log_q.push_back({1'b1, mem_addr, mem_wdata});
    else if (mem_read === 1'b1) log_q.push_back({1'b0, mem_addr, 8'h00});
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    ref_mem[a] = d;
    @(negedge CLK);
    pl_we = 1'b0;
  endtask

  task automatic mem_compare(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check({tag, "_membad"}, bad, 0);
  endtask

  // Reference model: expected response, latency and strobe sequence per request.
  task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] l, input logic [15:0] w,
                       output logic [15:0] er, output int el);
    exp_q.delete();
    case (op)
      2'b00: begin
        er = {8'h00, ref_mem[a]};
        el = 2;
        exp_q.push_back({1'b0, a, 8'h00});
      end
      2'b01: begin
        er = {ref_mem[8'(a + 8'd1)], ref_mem[a]};
        el = 2;
        exp_q.push_back({1'b0, a, 8'h00});
      end
      2'b10: begin
        er = 16'h0000;
        el = 3;
        exp_q.push_back({1'b1, a, w[7:0]});
        exp_q.push_back({1'b1, 8'(a + 8'd1), w[15:8]});
        ref_mem[a] = w[7:0];
        ref_mem[8'(a + 8'd1)] = w[15:8];
      end
      default: begin
        er = {8'h00, l};
        el = 2 * int'(l) + 1;
        for (int i = 0; i < int'(l); i++) begin
          logic [7:0] s, t, b;
          s = 8'(int'(a) + i);
          t = 8'(int'(d) + i);
          b = ref_mem[s];
          exp_q.push_back({1'b0, s, 8'h00});
          exp_q.push_back({1'b1, t, b});
          ref_mem[t] = b;
        end
      end
    endcase
  endtask

  // Present a request and return just after the accepting posedge.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] l, input logic [15:0] w);
    int n = 0;
    @(negedge CLK);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_dst   = d;
    req_len   = l;
    req_wdata = w;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("accept_ready", req_ready, 1);
    log_q.delete();
    @(posedge CLK);
  endtask

  // Called at a negedge lat0 cycles after acceptance; waits for the response.
  task automatic finish_op(input int lat0, input logic [15:0] er, input int el,
                           input string tag);
    int lat = lat0;
    int nlog;
    while (resp_valid !== 1'b1 && lat < 600) begin
      @(negedge CLK);
      lat++;
    end
    check({tag, "_lat"}, lat, el);
    check({tag, "_rdata"}, resp_rdata, er);
    check({tag, "_ready_done"}, req_ready, 0);
    nlog = log_q.size();
    check({tag, "_nstrobe"}, nlog, exp_q.size());
    for (int i = 0; i < nlog && i < exp_q.size(); i++)
      check({tag, "_strobe"}, log_q[i], exp_q[i]);
    @(negedge CLK);
    check({tag, "_resp_pulse"}, resp_valid, 0);
    check({tag, "_ready_idle"}, req_ready, 1);
    check({tag, "_rdata_hold"}, resp_rdata, er);
    mem_compare(tag);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] l, input logic [15:0] w, input string tag);
    logic [15:0] er;
    int el;
    model(op, a, d, l, w, er, el);
    issue(op, a, d, l, w);
    @(negedge CLK);
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = 8'($urandom);
    req_dst   = 8'($urandom);
    req_len   = 8'($urandom);
    req_wdata = 16'($urandom);
    finish_op(1, er, el, tag);
  endtask

  initial begin
    logic [15:0] er;
    int el;
    int wr;
    int seen;
    int strobes;

    // Reset with a pending request
    reset = 1'b0; req_valid = 1'b1; req_op = 2'b11; req_addr = 8'h10;
    req_dst = 8'h20; req_len = 8'h05; req_wdata = 16'h1234; pl_we = 1'b0;
    pl_addr = 8'h00; pl_data = 8'h00;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("rst_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
    end
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge CLK);
    check("rel_ready", req_ready, 1);

    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
    preload(8'd16, 8'd254);
    preload(8'd17, 8'd7);
    preload(8'd255, 8'd5);
    preload(8'd0, 8'd9);

    run_op(2'b00, 8'd16, 8'd0, 8'd0, 16'h0, "load8_16");
    check("load8_16_val", resp_rdata, 16'h00FE);
    run_op(2'b01, 8'd16, 8'd0, 8'd0, 16'h0, "load16_16");
    check("load16_16_val", resp_rdata, 16'h07FE);
    run_op(2'b01, 8'd255, 8'd0, 8'd0, 16'h0, "load16_wrap");
    check("load16_wrap_val", resp_rdata, 16'h0905);

    run_op(2'b10, 8'd255, 8'd0, 8'd0, 16'hBEEF, "store_wrap");
    check("store_m255", mem[255], 8'hEF);
    check("store_m0", mem[0], 8'hBE);

    preload(8'd16, 8'd1);
    preload(8'd17, 8'd2);
    preload(8'd18, 8'd3);
    run_op(2'b11, 8'd16, 8'd40, 8'd3, 16'h0, "copy3");
    check("copy3_m40", mem[40], 1);
    check("copy3_m42", mem[42], 3);
    run_op(2'b11, 8'd16, 8'd40, 8'd0, 16'h0, "copy0");

    // req_valid held high: second request taken on the first IDLE cycle
    model(2'b00, 8'd17, 8'd0, 8'd0, 16'h0, er, el);
    issue(2'b00, 8'd17, 8'd0, 8'd0, 16'h0);
    @(negedge CLK);
    req_op = 2'b00;
    req_addr = 8'd42;
    finish_op(1, er, el, "hold_first");
    log_q.delete();
    model(2'b00, 8'd42, 8'd0, 8'd0, 16'h0, er, el);
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    finish_op(1, er, el, "hold_second");

    // A request pulsed while busy is dropped
    model(2'b01, 8'd40, 8'd0, 8'd0, 16'h0, er, el);
    issue(2'b01, 8'd40, 8'd0, 8'd0, 16'h0);
    @(negedge CLK);
    req_op = 2'b10;
    req_addr = 8'd30;
    req_wdata = 16'hDEAD;
    @(negedge CLK);
    req_valid = 1'b0;
    finish_op(2, er, el, "busy_pulse");
    log_q.delete();
    repeat (4) @(negedge CLK);
    check("busy_pulse_nostrobe", log_q.size(), 0);
    check("busy_pulse_ready", req_ready, 1);

    // Reset in the middle of a long copy
    issue(2'b11, 8'd60, 8'd200, 8'd10, 16'h0);
    wr = 0;
    @(negedge CLK);
    req_valid = 1'b0;
    if (mem_write === 1'b1) wr++;
    for (int k = 0; k < 100 && wr < 3; k++) begin
      @(negedge CLK);
      if (mem_write === 1'b1) wr++;
    end
    check("midrst_writes", wr, 3);
    reset = 1'b0;
    @(negedge CLK);
    check("midrst_read", mem_read, 0);
    check("midrst_write", mem_write, 0);
    check("midrst_resp", resp_valid, 0);
    check("midrst_rdata", resp_rdata, 0);
    check("midrst_addr", mem_addr, 0);
    reset = 1'b1;
    seen = 0;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (resp_valid === 1'b1) seen++;
      if (mem_read === 1'b1 || mem_write === 1'b1) strobes++;
    end
    check("midrst_noresp", seen, 0);
    check("midrst_nostrobe", strobes, 0);
    for (int i = 0; i < 3; i++) ref_mem[8'(200 + i)] = ref_mem[8'(60 + i)];
    mem_compare("midrst");
    check("midrst_ready", req_ready, 1);

    // Randomized traffic
    for (int t = 0; t < 40; t++)
      run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
             8'($urandom_range(0, 12)), 16'($urandom), "rand");

    check("rw_exclusive", both_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
